// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter (LSB first) with a small input FIFO and a valid/ready byte port.
// Bit timing uses a free-running 16x-oversample tick; one bit lasts 16 ticks.
module uart_tx_fifo #(
   parameter int CLK_TICKS  = 54,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [7:0]                    tx_data_i,
   input  logic                          tx_valid_i,
   output logic                          tx_ready_o,
   output logic                          tx_o,
   output logic                          busy_o,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

   // state | meaning
   // IDLE  | line high, waiting for a queued byte on a tick
   // START | start bit (low) for 16 ticks
   // DATA  | eight data bits, LSB first, 16 ticks each
   // STOP  | stop bit (high); chains straight into START if a byte is queued
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = (CLK_TICKS > 0) ? $clog2(CLK_TICKS + 1) : 1;
   localparam logic [TW-1:0] DIV_MAX = TW'(CLK_TICKS);
   localparam logic [CW-1:0] FULL    = CW'(FIFO_DEPTH);

   logic [TW-1:0] div_q;
   logic          baud_tick;

   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q, count_d;
   logic          push, pop;

   state_t        state_q, state_d;
   logic [3:0]    tick_cnt_q, tick_cnt_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;
   logic          busy_q;

   assign baud_tick    = (div_q == DIV_MAX);
   assign tx_ready_o   = (count_q != FULL);
   assign push         = tx_valid_i && tx_ready_o;
   assign tx_o         = tx_q;
   assign busy_o       = busy_q;
   assign fifo_count_o = count_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         div_q <= '0;
      end else if (baud_tick) begin
         div_q <= '0;
      end else begin
         div_q <= div_q + TW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wr_ptr_q] <= tx_data_i;
      end
   end

   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_d;
      end
   end

   // Pops look only at the registered count, so a byte is never sent in its push cycle.
   always_comb begin
      state_d    = state_q;
      tick_cnt_d = tick_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      tx_d       = tx_q;
      pop        = 1'b0;
      if (baud_tick) begin
         case (state_q)
            IDLE: begin
               tx_d = 1'b1;
               if (count_q != '0) begin
                  pop        = 1'b1;
                  shift_d    = mem_q[rd_ptr_q];
                  tx_d       = 1'b0;
                  tick_cnt_d = '0;
                  state_d    = START;
               end
            end
            START: begin
               tx_d       = 1'b0;
               tick_cnt_d = tick_cnt_q + 4'd1;
               if (tick_cnt_q == 4'd15) begin
                  tx_d       = shift_q[0];
                  bit_cnt_d  = '0;
                  tick_cnt_d = '0;
                  state_d    = DATA;
               end
            end
            DATA: begin
               tick_cnt_d = tick_cnt_q + 4'd1;
               if (tick_cnt_q == 4'd15) begin
                  tick_cnt_d = '0;
                  shift_d    = {1'b0, shift_q[7:1]};
                  if (bit_cnt_q == 3'd7) begin
                     tx_d    = 1'b1;
                     state_d = STOP;
                  end else begin
                     bit_cnt_d = bit_cnt_q + 3'd1;
                     tx_d      = shift_q[1];
                  end
               end
            end
            STOP: begin
               tx_d       = 1'b1;
               tick_cnt_d = tick_cnt_q + 4'd1;
               if (tick_cnt_q == 4'd15) begin
                  tick_cnt_d = '0;
                  if (count_q != '0) begin
                     pop     = 1'b1;
                     shift_d = mem_q[rd_ptr_q];
                     tx_d    = 1'b0;
                     state_d = START;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
            default: begin
               tx_d    = 1'b1;
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         tick_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
         busy_q     <= (state_q != IDLE) || (count_q != '0);
      end
   end

endmodule
